// File: rtl/decode_regfile_fwd.sv
// decode_regfile_fwd
//   Y86 decode / write-back stage. Decodes source and destination register IDs
//   from icode/rA/rB, reads operands from an internal register file with a
//   write-through bypass, commits the E and M write-back ports, and presents
//   the decoded instruction through a one-deep valid/ready output register.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    decode request handshake
//   in_icode, in_rA, in_rB instruction fields; in_cnd is the cmovXX condition
//   wb_dstE / wb_valE      write-back E port (RNONE = no write)
//   wb_dstM / wb_valM      write-back M port (RNONE = no write), wins over E
//   out_valid / out_ready  output handshake
//   out_icode, out_src*, out_dst*, out_val*, out_inv   registered decode result
module decode_regfile_fwd #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int RID_W  = 4,
    parameter int RSP_ID = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [RID_W-1:0]  in_rA,
    input  logic [RID_W-1:0]  in_rB,
    input  logic              in_cnd,
    input  logic [RID_W-1:0]  wb_dstE,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [RID_W-1:0]  wb_dstM,
    input  logic [DATA_W-1:0] wb_valM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [RID_W-1:0]  out_srcA,
    output logic [RID_W-1:0]  out_srcB,
    output logic [RID_W-1:0]  out_dstE,
    output logic [RID_W-1:0]  out_dstM,
    output logic [DATA_W-1:0] out_valA,
    output logic [DATA_W-1:0] out_valB,
    output logic              out_inv
);

    localparam logic [RID_W-1:0] RNONE  = '1;
    localparam logic [RID_W-1:0] RSP    = RID_W'(RSP_ID);
    localparam logic [RID_W:0]   NREG_W = (RID_W+1)'(NREG);

    // IDs that name no implemented register behave exactly like RNONE.
    function automatic logic [RID_W-1:0] clean_id(input logic [RID_W-1:0] id);
        return ({1'b0, id} >= NREG_W) ? RNONE : id;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [RID_W-1:0] src_a_next, src_b_next, dst_e_next, dst_m_next;
    logic [RID_W-1:0] src_a_raw, src_b_raw, dst_e_raw, dst_m_raw;
    logic             inv_next;

    always_comb begin
        src_a_raw = RNONE;
        src_b_raw = RNONE;
        dst_e_raw = RNONE;
        dst_m_raw = RNONE;
        inv_next  = 1'b0;
        case (in_icode)
            4'h2: begin src_a_raw = in_rA; dst_e_raw = in_cnd ? in_rB : RNONE; end
            4'h3: begin dst_e_raw = in_rB; end
            4'h4: begin src_a_raw = in_rA; src_b_raw = in_rB; end
            4'h5: begin src_b_raw = in_rB; dst_m_raw = in_rA; end
            4'h6: begin src_a_raw = in_rA; src_b_raw = in_rB; dst_e_raw = in_rB; end
            4'h8: begin src_b_raw = RSP;   dst_e_raw = RSP; end
            4'h9: begin src_a_raw = RSP;   src_b_raw = RSP; dst_e_raw = RSP; end
            4'hA: begin src_a_raw = in_rA; src_b_raw = RSP; dst_e_raw = RSP; end
            4'hB: begin src_a_raw = RSP;   src_b_raw = RSP; dst_e_raw = RSP; dst_m_raw = in_rA; end
            4'h0, 4'h1, 4'h7: ;
            default: inv_next = 1'b1;
        endcase
        src_a_next = clean_id(src_a_raw);
        src_b_next = clean_id(src_b_raw);
        dst_e_next = clean_id(dst_e_raw);
        dst_m_next = clean_id(dst_m_raw);
    end

    // ------------------------------------------------------------------
    // Register file: flop array so every entry clears on reset and both
    // read ports see the whole file combinationally.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_reg [NREG];
    logic [RID_W-1:0]  wb_dst_e_c, wb_dst_m_c;

    assign wb_dst_e_c = clean_id(wb_dstE);
    assign wb_dst_m_c = clean_id(wb_dstM);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            localparam logic [RID_W-1:0] IDX = RID_W'(gi);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wb_dst_m_c == IDX) begin
                    rf_reg[gi] <= wb_valM;   // M beats E on a shared target (popq %rsp)
                end else if (wb_dst_e_c == IDX) begin
                    rf_reg[gi] <= wb_valE;
                end
            end
        end
    endgenerate

    // Operand read with same-cycle bypass: the value seen is what the
    // register will hold after this edge's write-back.
    function automatic logic [DATA_W-1:0] read_op(
        input logic [RID_W-1:0]  id,
        input logic [DATA_W-1:0] rf_val
    );
        if (id == RNONE)           return '0;
        else if (id == wb_dst_m_c) return wb_valM;
        else if (id == wb_dst_e_c) return wb_valE;
        else                       return rf_val;
    endfunction

    logic [DATA_W-1:0] rf_a, rf_b, val_a_next, val_b_next;

    // RNONE never reaches the file lookup result (read_op masks it), so the
    // index is only meaningful for implemented registers.
    assign rf_a       = (src_a_next == RNONE) ? '0 : rf_reg[src_a_next];
    assign rf_b       = (src_b_next == RNONE) ? '0 : rf_reg[src_b_next];
    assign val_a_next = read_op(src_a_next, rf_a);
    assign val_b_next = read_op(src_b_next, rf_b);

    // ------------------------------------------------------------------
    // Output register / handshake
    // ------------------------------------------------------------------
    logic              valid_reg, inv_reg;
    logic [3:0]        icode_reg;
    logic [RID_W-1:0]  src_a_reg, src_b_reg, dst_e_reg, dst_m_reg;
    logic [DATA_W-1:0] val_a_reg, val_b_reg;
    logic              xfer;

    assign in_ready = !valid_reg || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            icode_reg <= 4'h0;
            src_a_reg <= RNONE;
            src_b_reg <= RNONE;
            dst_e_reg <= RNONE;
            dst_m_reg <= RNONE;
            val_a_reg <= '0;
            val_b_reg <= '0;
            inv_reg   <= 1'b0;
        end else if (xfer) begin
            valid_reg <= 1'b1;
            icode_reg <= in_icode;
            src_a_reg <= src_a_next;
            src_b_reg <= src_b_next;
            dst_e_reg <= dst_e_next;
            dst_m_reg <= dst_m_next;
            val_a_reg <= val_a_next;
            val_b_reg <= val_b_next;
            inv_reg   <= inv_next;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_icode = icode_reg;
    assign out_srcA  = src_a_reg;
    assign out_srcB  = src_b_reg;
    assign out_dstE  = dst_e_reg;
    assign out_dstM  = dst_m_reg;
    assign out_valA  = val_a_reg;
    assign out_valB  = val_b_reg;
    assign out_inv   = inv_reg;

endmodule
